// File: rtl/dii_package.sv
// Shared debug-interconnect (DII) flit type used by every DII producer and consumer.
// Latency: n/a (types only).
// Backpressure: n/a. Each flit carries valid, last-of-packet and a 16-bit payload word.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_dii_packet_arbiter_pkg.sv
// Local types and helpers for the DII packet arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. Holds the arbiter state encoding and the round-robin pointer step.
package osd_dii_packet_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Next round-robin start position: one past the winner, wrapping to port 0.
    function automatic int rr_next(input int idx, input int num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/osd_dii_packet_arbiter_rr_select.sv
// osd_rr_select: round-robin pick of the first requester at or after ptr, wrapping at NUM_PORTS-1.
// Latency: purely combinational.
// Backpressure: none; ports are req (requests), ptr (start index), grant (one-hot), idx (winner), any.
module osd_rr_select #(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // Walk the ports in priority order starting at ptr; first hit wins.
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = IDX_W'((int'(ptr) + off) % NUM_PORTS);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_dii_packet_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS DII flit streams onto one registered DII output.
// Latency: one cycle from input acceptance to out_flit; sustains one flit per cycle.
// Backpressure: out_ready low with a valid output freezes everything and drops all in_ready.
// Ports: clk/rst (async, active-high), in_flit/in_ready per input, out_flit/out_ready merged,
//        owner/locked report the port holding an in-progress multi-flit packet.
module osd_dii_packet_arbiter
    import dii_package::*;
    import osd_dii_packet_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  dii_flit              in_flit [NUM_PORTS],
    output logic [NUM_PORTS-1:0] in_ready,
    output dii_flit              out_flit,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     owner,
    output logic                 locked
);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    dii_flit              out_q, out_d;

    logic [NUM_PORTS-1:0] req_vld;
    logic [NUM_PORTS-1:0] sel_grant;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;

    logic                 load;
    logic                 accept;
    logic [IDX_W-1:0]     acc_idx;
    dii_flit              acc_flit;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
        assign req_vld[i] = in_flit[i].valid;
    end

    osd_rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_select (
        .req   (req_vld),
        .ptr   (rr_ptr_q),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    always_comb begin
        // The output register can take a new flit when empty or being drained this cycle.
        load     = !out_q.valid || out_ready;
        in_ready = '0;
        acc_idx  = sel_idx;

        if (state_q == ARB_LOCKED) begin
            in_ready[owner_q] = load;
            acc_idx           = owner_q;
        end else if (sel_any && load) begin
            in_ready = sel_grant;
        end
        // Nothing may be accepted while reset is held, even with sources still valid.
        if (rst) begin
            in_ready = '0;
        end

        accept   = |(in_ready & req_vld);
        acc_flit = in_flit[acc_idx];

        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        out_d    = out_q;

        if (accept) begin
            out_d       = acc_flit;
            out_d.valid = 1'b1;
            if (state_q == ARB_IDLE) begin
                // Pointer advances at the head flit; it is left alone for the packet body.
                rr_ptr_d = IDX_W'(rr_next(int'(sel_idx), NUM_PORTS));
                if (!acc_flit.last) begin
                    state_d = ARB_LOCKED;
                    owner_d = sel_idx;
                end
            end else if (acc_flit.last) begin
                state_d = ARB_IDLE;
            end
        end else if (out_ready) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            out_q    <= out_d;
        end
    end

    assign out_flit = out_q;
    assign owner    = owner_q;
    assign locked   = (state_q == ARB_LOCKED);

endmodule
